// File: rtl/sample_transmitter.sv
// sample_transmitter: buffers 32-bit sample words in a small word FIFO and
// serializes each word LSB-byte-first onto a valid/ready byte interface,
// skipping bytes whose channel group was disabled when the word was accepted.
// Optional build macro: SAMPLE_TRANSMITTER_TX_COUNT_EN (completed-word counter).
//
// FSM states:
//   state | meaning
//   IDLE  | shift register empty, waiting for a buffered word
//   SEND  | word_r/mask_r loaded; emitting enabled bytes, lowest group first

module sample_transmitter #(
    parameter int WORD_FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        resetnn,
    input  logic        send,
    input  logic [31:0] wrdata,
    input  logic [3:0]  disabledGroups,
    output logic        busy,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        overflow,
    output logic [31:0] tx_count
);

    localparam int AW = (WORD_FIFO_DEPTH > 2) ? $clog2(WORD_FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(WORD_FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Each entry holds {disabledGroups, wrdata} as captured at accept time.
    logic [35:0]   fifoMem [WORD_FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] fifoCount;
    logic [CW-1:0] fifoCountNext;
    logic          fifoEmpty;
    logic          busyR;
    logic          overflowR;
    logic          wrEn;
    logic [35:0]   headEntry;

    state_t        stateR;
    state_t        stateNext;
    logic [31:0]   wordR;
    logic [31:0]   wordNext;
    logic [3:0]    maskR;
    logic [3:0]    maskNext;
    logic [3:0]    lowBit;
    logic          byteValidR;
    logic [7:0]    byteDataR;
    logic          handshake;
    logic          pop;
    logic          complete;

    // Byte of the word selected by the lowest set bit of the send mask.
    function automatic logic [7:0] pickByte(input logic [31:0] w, input logic [3:0] m);
        logic [7:0] b;
        b = 8'h00;
        if (m[0])      b = w[7:0];
        else if (m[1]) b = w[15:8];
        else if (m[2]) b = w[23:16];
        else if (m[3]) b = w[31:24];
        return b;
    endfunction

    assign fifoEmpty = (fifoCount == '0);
    assign wrEn      = send & ~busyR;
    assign headEntry = fifoMem[rdPtr];
    assign handshake = byteValidR & byte_ready;
    assign lowBit    = maskR & (~maskR + 4'd1);

    // Word storage; contents are only meaningful between write and pop.
    always_ff @(posedge clock) begin
        if (wrEn) begin
            fifoMem[wrPtr] <= {disabledGroups, wrdata};
        end
    end

    // Next occupancy: a simultaneous write and pop leaves it unchanged.
    always_comb begin
        fifoCountNext = fifoCount;
        case ({wrEn, pop})
            2'b10:   fifoCountNext = fifoCount + 1'b1;
            2'b01:   fifoCountNext = fifoCount - 1'b1;
            default: fifoCountNext = fifoCount;
        endcase
    end

    // FIFO pointers, occupancy, registered busy flag and sticky overflow.
    always_ff @(posedge clock or negedge resetnn) begin
        if (!resetnn) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            busyR     <= 1'b0;
            overflowR <= 1'b0;
        end else begin
            if (wrEn) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            fifoCount <= fifoCountNext;
            busyR     <= (fifoCountNext == FULL_COUNT);
            if (send && busyR) overflowR <= 1'b1;
        end
    end

    // Next-state decode: byte retirement, word completion and back-to-back pop.
    always_comb begin
        stateNext = stateR;
        wordNext  = wordR;
        maskNext  = maskR;
        pop       = 1'b0;
        complete  = 1'b0;
        case (stateR)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    wordNext  = headEntry[31:0];
                    maskNext  = ~headEntry[35:32];
                    stateNext = SEND;
                end
            end
            SEND: begin
                // An all-disabled word has an empty mask and retires immediately.
                if (maskR == 4'd0) begin
                    complete = 1'b1;
                end else if (handshake) begin
                    maskNext = maskR & ~lowBit;
                    complete = (maskNext == 4'd0);
                end
                if (complete) begin
                    if (!fifoEmpty) begin
                        pop      = 1'b1;
                        wordNext = headEntry[31:0];
                        maskNext = ~headEntry[35:32];
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // FSM registers with registered byte outputs derived from the next mask.
    always_ff @(posedge clock or negedge resetnn) begin
        if (!resetnn) begin
            stateR     <= IDLE;
            wordR      <= '0;
            maskR      <= '0;
            byteValidR <= 1'b0;
            byteDataR  <= '0;
        end else begin
            stateR     <= stateNext;
            wordR      <= wordNext;
            maskR      <= maskNext;
            byteValidR <= (stateNext == SEND) && (maskNext != 4'd0);
            byteDataR  <= (stateNext == SEND) ? pickByte(wordNext, maskNext) : 8'h00;
        end
    end

`ifdef SAMPLE_TRANSMITTER_TX_COUNT_EN
    logic [31:0] txCountR;

    // Saturating count of completed words, including all-disabled ones.
    always_ff @(posedge clock or negedge resetnn) begin
        if (!resetnn) begin
            txCountR <= '0;
        end else if (complete && (txCountR != 32'hFFFF_FFFF)) begin
            txCountR <= txCountR + 32'd1;
        end
    end

    assign tx_count = txCountR;
`else
    assign tx_count = 32'd0;
`endif

    assign busy       = busyR;
    assign overflow   = overflowR;
    assign byte_valid = byteValidR;
    assign byte_data  = byteDataR;

endmodule
